// File: rtl/gray_stream_filter_if.sv
// Pixel-stream bundle for gray_stream_filter.
// Upstream side: one_px ({pad,R,G,B}), i_in_valid, i_mode, o_in_ready.
// Downstream side: grayed_one_px, o_valid, o_last, i_out_ready.
// The master modport is used by whoever drives pixels and accepts results.
// The slave modport is used by the filter itself.
interface gray_stream_filter_if #(
  parameter int CH_BW  = 8,
  parameter int OUT_BW = 8
);
  logic [4*CH_BW-1:0] one_px;
  logic               i_in_valid;
  logic               o_in_ready;
  logic               i_mode;
  logic [OUT_BW-1:0]  grayed_one_px;
  logic               o_valid;
  logic               i_out_ready;
  logic               o_last;

  modport master (
    output one_px, i_in_valid, i_mode, i_out_ready,
    input  o_in_ready, grayed_one_px, o_valid, o_last
  );

  modport slave (
    input  one_px, i_in_valid, i_mode, i_out_ready,
    output o_in_ready, grayed_one_px, o_valid, o_last
  );
endinterface

// File: rtl/gray_stream_filter.sv
// gray_stream_filter: RGB pixel stream to gray, 3-stage valid/ready pipeline.
//   S1 per-channel multiply, S2 sum, S3 round/scale.
//   The whole pipeline freezes while the output is stalled (o_valid && !i_out_ready).
// Ports:
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   bus (slave)    one_px / i_in_valid / i_mode / o_in_ready in,
//                  grayed_one_px / o_valid / o_last / i_out_ready out
// Optional macro GRAY_BIN_EN adds i_thresh (OUT_BW) and o_bin (registered
// grayed_one_px >= i_thresh, where i_thresh is sampled at S3).
module gray_stream_filter #(
  parameter int CH_BW    = 8,
  parameter int OUT_BW   = 8,
  parameter int FRAME_PX = 784,
  parameter int WR       = 77,
  parameter int WG       = 150,
  parameter int WB       = 29
) (
  input  logic                 clk,
  input  logic                 reset_n,
  gray_stream_filter_if.slave  bus
`ifdef GRAY_BIN_EN
  ,
  input  logic [OUT_BW-1:0]    i_thresh,
  output logic                 o_bin
`endif
);
  localparam int STAGES = 3;
  localparam int SW     = CH_BW + 9;
  localparam int CW     = (FRAME_PX > 1) ? $clog2(FRAME_PX) : 1;

  logic [CH_BW-1:0]   w_r, w_g, w_b;
  logic [8:0]         w_wr, w_wg, w_wb;
  logic               w_stall, w_acc, w_is_last;
  logic [SW-1:0]      w_rnd;
  logic [CH_BW-1:0]   w_res;
  logic [OUT_BW-1:0]  w_gray;
  logic               w_unused;

  logic [STAGES:1]    r_vld_pipe;
  logic [CW-1:0]      r_cnt;
  logic [SW-1:0]      r_p_r, r_p_g, r_p_b;
  logic               r_last1, r_last2, r_last3;
  logic [SW-1:0]      r_sum;
  logic [OUT_BW-1:0]  r_gray;

  assign w_r = bus.one_px[3*CH_BW-1 -: CH_BW];
  assign w_g = bus.one_px[2*CH_BW-1 -: CH_BW];
  assign w_b = bus.one_px[CH_BW-1:0];
  assign w_unused = ^bus.one_px[4*CH_BW-1 -: CH_BW];

  // Weights are picked per pixel at S1, so the mode never needs to ride further.
  assign w_wr = bus.i_mode ? 9'd85 : 9'(WR);
  assign w_wg = bus.i_mode ? 9'd86 : 9'(WG);
  assign w_wb = bus.i_mode ? 9'd85 : 9'(WB);

  assign w_stall        = r_vld_pipe[STAGES] && !bus.i_out_ready;
  assign bus.o_in_ready = !w_stall;
  assign w_acc          = bus.i_in_valid && !w_stall;
  assign w_is_last      = (r_cnt == CW'(FRAME_PX - 1));

  // Weights sum to 256, so sum+128 fits SW bits and the >>8 result fits CH_BW.
  assign w_rnd  = r_sum + SW'(128);
  assign w_res  = CH_BW'(w_rnd >> 8);
  assign w_gray = OUT_BW'(w_res >> (CH_BW - OUT_BW));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= w_is_last ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld_pipe <= '0;
      r_p_r      <= '0;
      r_p_g      <= '0;
      r_p_b      <= '0;
      r_last1    <= 1'b0;
      r_sum      <= '0;
      r_last2    <= 1'b0;
      r_gray     <= '0;
      r_last3    <= 1'b0;
    end else if (!w_stall) begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], w_acc};
      if (w_acc) begin
        r_p_r   <= SW'(w_r) * SW'(w_wr);
        r_p_g   <= SW'(w_g) * SW'(w_wg);
        r_p_b   <= SW'(w_b) * SW'(w_wb);
        r_last1 <= w_is_last;
      end
      if (r_vld_pipe[1]) begin
        r_sum   <= r_p_r + r_p_g + r_p_b;
        r_last2 <= r_last1;
      end
      if (r_vld_pipe[2]) begin
        r_gray <= w_gray;
      end
      // o_last only ever qualifies a valid result.
      r_last3 <= r_vld_pipe[2] && r_last2;
    end
  end

`ifdef GRAY_BIN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_bin <= 1'b0;
    end else if (!w_stall && r_vld_pipe[2]) begin
      o_bin <= (w_gray >= i_thresh);
    end
  end
`endif

  assign bus.o_valid       = r_vld_pipe[STAGES];
  assign bus.grayed_one_px = r_gray;
  assign bus.o_last        = r_last3;
endmodule

// File: tb/tb_gray_stream_filter.sv
module tb_gray_stream_filter;
  localparam int CH_BW    = 8;
  localparam int OUT_BW   = 8;
  localparam int FRAME_PX = 784;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  gray_stream_filter_if #(.CH_BW(CH_BW), .OUT_BW(OUT_BW)) bus();
`ifdef GRAY_BIN_EN
  logic [OUT_BW-1:0] i_thresh;
  logic              o_bin;
`endif

  gray_stream_filter #(.CH_BW(CH_BW), .OUT_BW(OUT_BW), .FRAME_PX(FRAME_PX)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
`ifdef GRAY_BIN_EN
    ,
    .i_thresh(i_thresh),
    .o_bin(o_bin)
`endif
  );

  typedef struct {
    logic [OUT_BW-1:0] g;
    logic              last;
  } exp_t;

  exp_t q[$];
  int   mdl_cnt;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference: weighted mean with round-half-up, then keep the top OUT_BW bits.
  function automatic logic [OUT_BW-1:0] ref_gray(input logic [31:0] px, input bit m);
    int r, g, b, wr, wg, wb, y;
    r  = int'(px[23:16]);
    g  = int'(px[15:8]);
    b  = int'(px[7:0]);
    wr = m ? 85 : 77;
    wg = m ? 86 : 150;
    wb = m ? 85 : 29;
    y  = (r*wr + g*wg + b*wb + 128) / 256;
    return OUT_BW'(y >> (CH_BW - OUT_BW));
  endfunction

  // Drives one cycle of inputs and records any accepted pixel in the model.
  // Returns at negedge+1, so DUT outputs can be read until the next posedge.
  task automatic tick(input bit v, input logic [31:0] px, input bit m, input bit rdy,
                      output bit acc, output bit con);
    exp_t e;
    @(negedge clk);
    bus.i_in_valid  = v;
    bus.one_px      = px;
    bus.i_mode      = m;
    bus.i_out_ready = rdy;
    #1;
    acc = v && (bus.o_in_ready === 1'b1);
    con = (bus.o_valid === 1'b1) && rdy;
    if (acc) begin
      e.g    = ref_gray(px, m);
      e.last = (mdl_cnt == FRAME_PX - 1);
      q.push_back(e);
      mdl_cnt = (mdl_cnt + 1) % FRAME_PX;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.i_in_valid  = 1'b0;
    bus.i_out_ready = 1'b1;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q.delete();
    mdl_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    bus.i_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.grayed_one_px !== '0 ||
        bus.o_in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b last=%b gray=%h in_ready=%b, expected 0 0 00 1",
               bus.o_valid, bus.o_last, bus.grayed_one_px, bus.o_in_ready);
    end
    reset_n = 1'b1;
    q.delete();
    mdl_cnt = 0;
  endtask

  task automatic test_vectors();
    logic [31:0]       px  [6] = '{32'h00FF0000, 32'h00FFFFFF, 32'h00000000,
                                   32'h00306090, 32'h007F7F7F, 32'h00808080};
    bit                md  [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [OUT_BW-1:0] exv [6] = '{8'h4D, 8'hFF, 8'h00, 8'h60, 8'h7F, 8'h80};
    bit acc, con;
    int lat;
    exp_t e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      tick(1'b1, px[i], md[i], 1'b1, acc, con);
      lat = 0;
      con = 1'b0;
      while (!con && lat < 8) begin
        tick(1'b0, 32'h0, 1'b0, 1'b1, acc, con);
        lat++;
      end
      n_tests++;
      if (!con || lat != 3 || bus.grayed_one_px !== exv[i]) begin
        n_fail++;
        $display("FAIL vector%0d: got gray=%h latency=%0d, expected gray=%h latency=3",
                 i, bus.grayed_one_px, lat, exv[i]);
      end
      if (q.size() > 0) e = q.pop_front();
    end
  endtask

  task automatic test_back_to_back();
    bit acc, con;
    int idx = 0;
    int guard = 0;
    exp_t e;
    do_reset();
    while ((idx < FRAME_PX + 1) && guard < FRAME_PX + 20) begin
      guard++;
      tick(1'b1, $urandom & 32'h00FFFFFF, 1'($urandom_range(0, 1)), 1'b1, acc, con);
      if (con) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_out: unexpected result gray=%h, expected none", bus.grayed_one_px);
        end else begin
          e = q.pop_front();
          if (bus.grayed_one_px !== e.g || bus.o_last !== e.last ||
              bus.o_last !== (idx == FRAME_PX - 1)) begin
            n_fail++;
            $display("FAIL b2b_px%0d: got gray=%h last=%b, expected gray=%h last=%b",
                     idx, bus.grayed_one_px, bus.o_last, e.g, (idx == FRAME_PX - 1));
          end
        end
        idx++;
      end
    end
    n_tests++;
    if (idx < FRAME_PX + 1) begin
      n_fail++;
      $display("FAIL b2b_count: got %0d results, expected %0d", idx, FRAME_PX + 1);
    end
  endtask

  task automatic test_stall();
    bit acc, con;
    logic [OUT_BW-1:0] hg;
    logic hl;
    int guard;
    exp_t e;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      // first 4 cycles fill, next 5 stall, rest resume
      bit rdy = !(i >= 4 && i < 9);
      tick(1'b1, $urandom & 32'h00FFFFFF, 1'($urandom_range(0, 1)), rdy, acc, con);
      if (!rdy) begin
        if (i == 4) begin
          hg = bus.grayed_one_px;
          hl = bus.o_last;
          n_tests++;
          if (q.size() == 0 || hg !== q[0].g) begin
            n_fail++;
            $display("FAIL stall_head: got gray=%h, expected gray=%h",
                     hg, (q.size() > 0) ? q[0].g : 8'h00);
          end
        end
        n_tests++;
        if (bus.o_in_ready !== 1'b0 || bus.o_valid !== 1'b1 ||
            bus.grayed_one_px !== hg || bus.o_last !== hl) begin
          n_fail++;
          $display("FAIL stall_hold%0d: got in_ready=%b valid=%b gray=%h last=%b, expected 0 1 %h %b",
                   i, bus.o_in_ready, bus.o_valid, bus.grayed_one_px, bus.o_last, hg, hl);
        end
      end
      if (con) begin
        n_tests++;
        e = (q.size() > 0) ? q.pop_front() : '{8'hxx, 1'bx};
        if (bus.grayed_one_px !== e.g || bus.o_last !== e.last) begin
          n_fail++;
          $display("FAIL stall_out: got gray=%h last=%b, expected gray=%h last=%b",
                   bus.grayed_one_px, bus.o_last, e.g, e.last);
        end
      end
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      guard++;
      tick(1'b0, 32'h0, 1'b0, 1'b1, acc, con);
      if (con) begin
        e = q.pop_front();
        n_tests++;
        if (bus.grayed_one_px !== e.g || bus.o_last !== e.last) begin
          n_fail++;
          $display("FAIL stall_drain: got gray=%h last=%b, expected gray=%h last=%b",
                   bus.grayed_one_px, bus.o_last, e.g, e.last);
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_lost: got %0d results missing, expected 0", q.size());
    end
  endtask

  task automatic test_random();
    bit acc, con, v, rdy, ov;
    int guard;
    exp_t e;
    for (int i = 0; i < 3000; i++) begin
      v   = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 6) || (i >= 2980);
      tick(v, $urandom & 32'h00FFFFFF, 1'($urandom_range(0, 1)), rdy, acc, con);
      ov = (bus.o_valid === 1'b1);
      if (bus.o_in_ready !== !(ov && !rdy)) begin
        n_tests++;
        n_fail++;
        $display("FAIL rand_ready: got in_ready=%b, expected %b", bus.o_in_ready, !(ov && !rdy));
      end
      if (con) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL rand_out: unexpected result gray=%h, expected none", bus.grayed_one_px);
        end else begin
          e = q.pop_front();
          if (bus.grayed_one_px !== e.g || bus.o_last !== e.last) begin
            n_fail++;
            $display("FAIL rand_out: got gray=%h last=%b, expected gray=%h last=%b",
                     bus.grayed_one_px, bus.o_last, e.g, e.last);
          end
        end
      end
    end
    guard = 0;
    while (q.size() > 0 && guard < 20) begin
      guard++;
      tick(1'b0, 32'h0, 1'b0, 1'b1, acc, con);
      if (con) begin
        e = q.pop_front();
        n_tests++;
        if (bus.grayed_one_px !== e.g || bus.o_last !== e.last) begin
          n_fail++;
          $display("FAIL rand_drain: got gray=%h last=%b, expected gray=%h last=%b",
                   bus.grayed_one_px, bus.o_last, e.g, e.last);
        end
      end
    end
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL rand_lost: got %0d results missing, expected 0", q.size());
    end
  endtask

  task automatic test_reset_mid_frame();
    bit acc, con;
    int idx, guard;
    exp_t e;
    do_reset();
    for (int i = 0; i < 400; i++)
      tick(1'b1, $urandom & 32'h00FFFFFF, 1'b0, 1'b1, acc, con);
    // Asynchronous assertion between clock edges, with results in flight.
    #2;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_valid !== 1'b0 || bus.o_last !== 1'b0 || bus.grayed_one_px !== '0) begin
      n_fail++;
      $display("FAIL midreset_clear: got valid=%b last=%b gray=%h, expected 0 0 00",
               bus.o_valid, bus.o_last, bus.grayed_one_px);
    end
    bus.i_in_valid = 1'b0;
    q.delete();
    mdl_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    idx = 0;
    guard = 0;
    while (idx < FRAME_PX + 1 && guard < FRAME_PX + 20) begin
      guard++;
      tick(1'b1, $urandom & 32'h00FFFFFF, 1'b0, 1'b1, acc, con);
      if (con) begin
        n_tests++;
        e = (q.size() > 0) ? q.pop_front() : '{8'hxx, 1'bx};
        if (bus.grayed_one_px !== e.g || bus.o_last !== (idx == FRAME_PX - 1)) begin
          n_fail++;
          $display("FAIL midreset_px%0d: got gray=%h last=%b, expected gray=%h last=%b",
                   idx, bus.grayed_one_px, bus.o_last, e.g, (idx == FRAME_PX - 1));
        end
        idx++;
      end
    end
    n_tests++;
    if (idx < FRAME_PX + 1) begin
      n_fail++;
      $display("FAIL midreset_count: got %0d results, expected %0d", idx, FRAME_PX + 1);
    end
  endtask

`ifdef GRAY_BIN_EN
  task automatic test_bin();
    logic [31:0] px [2] = '{32'h007F7F7F, 32'h00808080};
    bit          exb[2] = '{1'b0, 1'b1};
    bit acc, con;
    int lat;
    exp_t e;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, px[i], 1'b0, 1'b1, acc, con);
      lat = 0;
      con = 1'b0;
      while (!con && lat < 8) begin
        tick(1'b0, 32'h0, 1'b0, 1'b1, acc, con);
        lat++;
      end
      n_tests++;
      if (!con || o_bin !== exb[i]) begin
        n_fail++;
        $display("FAIL bin%0d: got o_bin=%b gray=%h, expected o_bin=%b",
                 i, o_bin, bus.grayed_one_px, exb[i]);
      end
      if (q.size() > 0) e = q.pop_front();
    end
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n         = 1'b0;
    bus.one_px      = '0;
    bus.i_in_valid  = 1'b0;
    bus.i_mode      = 1'b0;
    bus.i_out_ready = 1'b1;
    mdl_cnt         = 0;
`ifdef GRAY_BIN_EN
    i_thresh = 8'h80;
`endif
    test_reset();
    test_vectors();
    test_back_to_back();
    test_stall();
    test_random();
    test_reset_mid_frame();
`ifdef GRAY_BIN_EN
    test_bin();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
